// File: rtl/inst_encoder.sv
// Instruction encoder: turns field-level requests into 32-bit MIPS-style
// words and streams them into instruction memory at sequential addresses.
// Each j/beq/bne can be followed by DELAY_NOPS auto-inserted NOP words.
// Once 2**ADDR_W words have been written, the block stops writing until reset.
//
// Handshake: a request is taken on a rising edge when in_valid && in_ready.
// in_ready is a registered function of state and full only. While in_ready
// is low, the requester holds in_valid and all fields stable.
module inst_encoder #(
  parameter int ADDR_W     = 8,
  parameter int DELAY_NOPS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic              nop_req,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       jaddr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]      LAST_PAD = 2'(DELAY_NOPS - 1);

  state_t            state_q;
  logic [1:0]        pad_cnt_q;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [ADDR_W:0]   count_q;
  logic              full_q;

  logic [31:0]       enc_d;
  logic              is_branch_d;
  logic [ADDR_W:0]   count_d;
  logic              hit_full_d;

  // Encode the presented request; nop_req overrides op_sel.
  always_comb begin
    enc_d       = 32'h0;
    is_branch_d = 1'b0;
    if (!nop_req) begin
      case (op_sel)
        3'd0: enc_d = {6'b000000, rs, rt, rd, 5'b00000, funct};
        3'd1: enc_d = {6'b001000, rs, rt, imm};
        3'd2: enc_d = {6'b001100, rs, rt, imm};
        3'd3: enc_d = {6'b100011, rs, rt, imm};
        3'd4: enc_d = {6'b101011, rs, rt, imm};
        3'd5: begin enc_d = {6'b000010, jaddr};    is_branch_d = 1'b1; end
        3'd6: begin enc_d = {6'b000100, rs, rt, imm}; is_branch_d = 1'b1; end
        default: begin enc_d = {6'b000101, rs, rt, imm}; is_branch_d = 1'b1; end
      endcase
    end
  end

  // Count after the write being launched this edge; full when it hits 2**ADDR_W.
  always_comb begin
    count_d    = count_q + 1'b1;
    hit_full_d = (count_d == FULL_CNT);
  end

  // Control FSM with registered outputs; count tracks words written including the one on wr_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pad_cnt_q  <= 2'd0;
      in_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 32'h0;
      count_q    <= '0;
      full_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= count_q[ADDR_W-1:0];
            wr_data_q <= enc_d;
            count_q   <= count_d;
            if (hit_full_d) begin
              state_q    <= FULL;
              full_q     <= 1'b1;
              in_ready_q <= 1'b0;
            end else if (is_branch_d && (DELAY_NOPS > 0)) begin
              state_q    <= PAD;
              pad_cnt_q  <= 2'd0;
              in_ready_q <= 1'b0;
            end
          end
        end
        PAD: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= count_q[ADDR_W-1:0];
          wr_data_q <= 32'h0;
          count_q   <= count_d;
          pad_cnt_q <= pad_cnt_q + 2'd1;
          if (hit_full_d) begin
            state_q <= FULL;
            full_q  <= 1'b1;
          end else if (pad_cnt_q == LAST_PAD) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= FULL;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign count    = count_q;
  assign full     = full_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder. Four instances with different parameters
// share one request bus; each has its own reset, and idle instances are
// held in reset while another is being exercised.
module tb_inst_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [2:0]  op_sel = 3'd0;
  logic        nop_req = 1'b0;
  logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0;
  logic [5:0]  funct = 6'd0;
  logic [15:0] imm = 16'd0;
  logic [25:0] jaddr = 26'd0;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;

  // a: ADDR_W=8 DELAY_NOPS=1
  logic       rdy_a, we_a, full_a;
  logic [7:0] wa_a;
  logic [31:0] wd_a;
  logic [8:0] cnt_a;
  logic [1:0] st_a;
  // b: ADDR_W=2 DELAY_NOPS=2
  logic       rdy_b, we_b, full_b;
  logic [1:0] wa_b;
  logic [31:0] wd_b;
  logic [2:0] cnt_b;
  logic [1:0] st_b;
  // c: ADDR_W=8 DELAY_NOPS=3
  logic       rdy_c, we_c, full_c;
  logic [7:0] wa_c;
  logic [31:0] wd_c;
  logic [8:0] cnt_c;
  logic [1:0] st_c;
  // d: ADDR_W=8 DELAY_NOPS=0
  logic       rdy_d, we_d, full_d;
  logic [7:0] wa_d;
  logic [31:0] wd_d;
  logic [8:0] cnt_d;
  logic [1:0] st_d;

  inst_encoder #(.ADDR_W(8), .DELAY_NOPS(1)) u_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid), .in_ready(rdy_a), .op_sel(op_sel),
    .nop_req(nop_req), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .jaddr(jaddr),
    .wr_en(we_a), .wr_addr(wa_a), .wr_data(wd_a), .count(cnt_a), .full(full_a), .state_o(st_a));
  inst_encoder #(.ADDR_W(2), .DELAY_NOPS(2)) u_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid), .in_ready(rdy_b), .op_sel(op_sel),
    .nop_req(nop_req), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .jaddr(jaddr),
    .wr_en(we_b), .wr_addr(wa_b), .wr_data(wd_b), .count(cnt_b), .full(full_b), .state_o(st_b));
  inst_encoder #(.ADDR_W(8), .DELAY_NOPS(3)) u_c (
    .clk(clk), .rst(rst_c), .in_valid(in_valid), .in_ready(rdy_c), .op_sel(op_sel),
    .nop_req(nop_req), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .jaddr(jaddr),
    .wr_en(we_c), .wr_addr(wa_c), .wr_data(wd_c), .count(cnt_c), .full(full_c), .state_o(st_c));
  inst_encoder #(.ADDR_W(8), .DELAY_NOPS(0)) u_d (
    .clk(clk), .rst(rst_d), .in_valid(in_valid), .in_ready(rdy_d), .op_sel(op_sel),
    .nop_req(nop_req), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .jaddr(jaddr),
    .wr_en(we_d), .wr_addr(wa_d), .wr_data(wd_d), .count(cnt_d), .full(full_d), .state_o(st_d));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled and inputs changed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [5:0] f, input logic [15:0] im,
                         input logic [25:0] ja, input logic nop);
    op_sel = op; rs = s; rt = t; rd = d; funct = f; imm = im; jaddr = ja; nop_req = nop;
    in_valid = 1'b1;
  endtask

  task automatic idle_req();
    in_valid = 1'b0; nop_req = 1'b0;
  endtask

  initial begin
    // ---------------- instance a: reset state, R-type, back-to-back ----------------
    step();
    rst_a = 1'b0;
    step();
    check("a_rst_wr_en", 64'(we_a), 64'd0);
    check("a_rst_wr_addr", 64'(wa_a), 64'd0);
    check("a_rst_wr_data", 64'(wd_a), 64'd0);
    check("a_rst_count", 64'(cnt_a), 64'd0);
    check("a_rst_full", 64'(full_a), 64'd0);
    check("a_rst_in_ready", 64'(rdy_a), 64'd1);

    set_req(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0);
    step();
    check("rtype_wr_en", 64'(we_a), 64'd1);
    check("rtype_wr_addr", 64'(wa_a), 64'd0);
    check("rtype_wr_data", 64'(wd_a), 64'h00221820);
    check("rtype_count", 64'(cnt_a), 64'd1);
    idle_req();
    step();
    check("rtype_after_wr_en", 64'(we_a), 64'd0);
    check("rtype_after_count", 64'(cnt_a), 64'd1);

    rst_a = 1'b1; step(); rst_a = 1'b0;
    set_req(3'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b0);
    step();
    check("addi_wr_data", 64'(wd_a), 64'h20220005);
    check("addi_wr_addr", 64'(wa_a), 64'd0);
    set_req(3'd3, 5'd29, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0);
    step();
    check("lw_wr_en", 64'(we_a), 64'd1);
    check("lw_wr_data", 64'(wd_a), 64'h8FA80004);
    check("lw_wr_addr", 64'(wa_a), 64'd1);
    set_req(3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'h00FF, 26'h0, 1'b0);
    step();
    check("andi_wr_data", 64'(wd_a), 64'h302200FF);
    set_req(3'd4, 5'd29, 5'd8, 5'd0, 6'h0, 16'h0008, 26'h0, 1'b0);
    step();
    check("sw_wr_data", 64'(wd_a), 64'hAFA80008);
    check("sw_wr_addr", 64'(wa_a), 64'd3);
    idle_req();
    step();
    check("b2b_idle_wr_en", 64'(we_a), 64'd0);
    check("b2b_count", 64'(cnt_a), 64'd4);

    // ---------------- instance a: beq + pad, j offered during pad ----------------
    rst_a = 1'b1; step(); rst_a = 1'b0;
    set_req(3'd6, 5'd3, 5'd4, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b0);
    step();
    check("beq_wr_data", 64'(wd_a), 64'h1064FFFF);
    check("beq_wr_addr", 64'(wa_a), 64'd0);
    check("beq_in_ready", 64'(rdy_a), 64'd0);
    check("beq_state_pad", 64'(st_a), 64'd1);
    set_req(3'd5, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b0);
    step();
    check("pad_wr_en", 64'(we_a), 64'd1);
    check("pad_wr_data", 64'(wd_a), 64'h0);
    check("pad_wr_addr", 64'(wa_a), 64'd1);
    check("pad_end_in_ready", 64'(rdy_a), 64'd1);
    step();
    check("j_wr_data", 64'(wd_a), 64'h08000010);
    check("j_wr_addr", 64'(wa_a), 64'd2);
    idle_req();
    step();
    check("j_pad_wr_data", 64'(wd_a), 64'h0);
    check("j_pad_wr_addr", 64'(wa_a), 64'd3);
    step();
    check("j_pad_done_wr_en", 64'(we_a), 64'd0);
    check("j_pad_done_count", 64'(cnt_a), 64'd4);

    // ---------------- instance a: nop_req overrides bne; all-zero R-type ----------------
    rst_a = 1'b1; step(); rst_a = 1'b0;
    set_req(3'd6, 5'd3, 5'd4, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b1);
    step();
    check("nop_wr_en", 64'(we_a), 64'd1);
    check("nop_wr_data", 64'(wd_a), 64'h0);
    check("nop_in_ready", 64'(rdy_a), 64'd1);
    check("nop_state_idle", 64'(st_a), 64'd0);
    set_req(3'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    step();
    check("zero_rtype_wr_en", 64'(we_a), 64'd1);
    check("zero_rtype_wr_data", 64'(wd_a), 64'h0);
    check("zero_rtype_count", 64'(cnt_a), 64'd2);
    idle_req();
    rst_a = 1'b1;

    // ---------------- instance b: fill to 4 words, then j at address 2 ----------------
    rst_b = 1'b1; step(); rst_b = 1'b0;
    set_req(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0);
    step(); step(); step();
    check("fill3_full", 64'(full_b), 64'd0);
    step();
    check("fill4_wr_en", 64'(we_b), 64'd1);
    check("fill4_wr_addr", 64'(wa_b), 64'd3);
    check("fill4_count", 64'(cnt_b), 64'd4);
    check("fill4_full", 64'(full_b), 64'd1);
    check("fill4_in_ready", 64'(rdy_b), 64'd0);
    step();
    check("fifth_no_write", 64'(we_b), 64'd0);
    step();
    check("full_hold_count", 64'(cnt_b), 64'd4);
    check("full_hold_wr_en", 64'(we_b), 64'd0);
    idle_req();
    rst_b = 1'b1; step(); rst_b = 1'b0;
    check("full_rst_count", 64'(cnt_b), 64'd0);
    check("full_rst_full", 64'(full_b), 64'd0);
    check("full_rst_in_ready", 64'(rdy_b), 64'd1);
    set_req(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0);
    step(); step();
    set_req(3'd5, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b0);
    step();
    check("b_j_wr_data", 64'(wd_b), 64'h08000010);
    check("b_j_wr_addr", 64'(wa_b), 64'd2);
    check("b_j_count", 64'(cnt_b), 64'd3);
    idle_req();
    step();
    check("b_pad_wr_en", 64'(we_b), 64'd1);
    check("b_pad_wr_addr", 64'(wa_b), 64'd3);
    check("b_pad_full", 64'(full_b), 64'd1);
    step();
    check("b_pad_dropped", 64'(we_b), 64'd0);
    check("b_pad_state_full", 64'(st_b), 64'd2);
    rst_b = 1'b1;

    // ---------------- instance c: reset during pad ----------------
    rst_c = 1'b1; step(); rst_c = 1'b0;
    set_req(3'd5, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FF, 1'b0);
    step();
    idle_req();
    check("c_j_wr_data", 64'(wd_c), 64'h080003FF);
    step();
    check("c_pad1_wr_addr", 64'(wa_c), 64'd1);
    rst_c = 1'b1;
    step();
    rst_c = 1'b0;
    check("c_rst_wr_en", 64'(we_c), 64'd0);
    check("c_rst_count", 64'(cnt_c), 64'd0);
    check("c_rst_wr_addr", 64'(wa_c), 64'd0);
    check("c_rst_in_ready", 64'(rdy_c), 64'd1);
    step();
    check("c_after_rst_wr_en", 64'(we_c), 64'd0);
    rst_c = 1'b1;

    // ---------------- instance d: no pad with DELAY_NOPS=0 ----------------
    rst_d = 1'b1; step(); rst_d = 1'b0;
    set_req(3'd7, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0003, 26'h0, 1'b0);
    step();
    idle_req();
    check("d_bne_wr_data", 64'(wd_d), 64'h14220003);
    check("d_bne_in_ready", 64'(rdy_d), 64'd1);
    step();
    check("d_no_pad_wr_en", 64'(we_d), 64'd0);
    check("d_count", 64'(cnt_d), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
